// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole controller.
//   state_t   : FSM encoding (IDLE, SHOW, HIT, MISS), 2 bits
//   POS_W     : width of a hole index
//   NUM_HOLES : number of holes / player switches
//   SCORE_MAX : saturation value of the hit counter
package mole_pkg;

  localparam int unsigned POS_W     = 3;
  localparam int unsigned NUM_HOLES = 8;
  localparam int unsigned SCORE_W   = 8;
  localparam int unsigned SCORE_MAX = 255;
  localparam int unsigned LFSR_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_HIT  = 2'd2,
    ST_MISS = 2'd3
  } state_t;

  // Pick the next hole from a random candidate, never repeating the current one.
  function automatic logic [POS_W-1:0] next_hole(input logic [POS_W-1:0] cand,
                                                 input logic [POS_W-1:0] cur);
    return (cand == cur) ? cand + POS_W'(1) : cand;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that steps every cycle.
//   clk   : clock
//   rst_n : asynchronous active-low reset, loads SEED (0 is mapped to 1)
//   cand  : low POS_W bits of the register, a candidate hole index
module mole_lfsr
  import mole_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [POS_W-1:0] cand
);

  // An all-zero state would lock the register up.
  localparam logic [LFSR_W-1:0] SEED_SAFE = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED_SAFE;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign cand = lfsr[POS_W-1:0];

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game controller: picks the mole hole, times each round and
// judges player switch toggles.
//   master_clk    : system clock
//   rst           : asynchronous active-low reset
//   en            : game enable level, 0 returns to IDLE
//   sw            : player switches (asynchronous), one per hole
//   mole_position : current mole hole
//   guess_correct : held high for FEEDBACK_TICKS after a hit
//   guess_wrong   : held high for FEEDBACK_TICKS after a wrong toggle or timeout
//   score         : hit count, saturating
// Optional feature macro: MOLE_SPEEDUP_EN (each hit shortens the show time).
module mole_game_ctrl
  import mole_pkg::*;
#(
  parameter int unsigned       TICK_DIV       = 100000,
  parameter int unsigned       MOLE_TICKS     = 1500,
  parameter int unsigned       FEEDBACK_TICKS = 500,
  parameter int unsigned       MIN_MOLE_TICKS = 300,
  parameter logic [LFSR_W-1:0] LFSR_SEED      = 8'hA5
) (
  input  logic                 master_clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_HOLES-1:0] sw,
  output logic [POS_W-1:0]     mole_position,
  output logic                 guess_correct,
  output logic                 guess_wrong,
  output logic [SCORE_W-1:0]   score
);

  localparam int unsigned TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TMR_MAX_A = (MOLE_TICKS > FEEDBACK_TICKS) ? MOLE_TICKS : FEEDBACK_TICKS;
  localparam int unsigned TMR_MAX   = (TMR_MAX_A > MIN_MOLE_TICKS) ? TMR_MAX_A : MIN_MOLE_TICKS;
  localparam int unsigned TMR_W     = $clog2(TMR_MAX + 1);
  localparam int unsigned SPEEDUP_STEP = 8;

  state_t               state, state_nxt;
  logic [POS_W-1:0]     pos_nxt;
  logic                 gc_nxt, gw_nxt;
  logic [SCORE_W-1:0]   score_nxt;
  logic [TMR_W-1:0]     timer, timer_nxt;
  logic [TICK_W-1:0]    tick_cnt;
  logic                 tick_c;
  logic [NUM_HOLES-1:0] s1, s2, s3;
  logic [NUM_HOLES-1:0] tog_c;
  logic                 hit_c;
  logic [POS_W-1:0]     cand;
  logic [POS_W-1:0]     fresh_c;

  // Game tick divider, free-running in every state.
  assign tick_c = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Two-flop synchroniser plus a history register for edge detection.
  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= sw;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tog_c = s2 ^ s3;
  // A hit is exactly one toggled bit and it is the mole's hole.
  assign hit_c = (tog_c == (NUM_HOLES'(1) << mole_position));

  mole_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk  (master_clk),
    .rst_n(rst),
    .cand (cand)
  );

  assign fresh_c = next_hole(cand, mole_position);

`ifdef MOLE_SPEEDUP_EN
  // Show time shrinks on every hit down to a floor; IDLE restores it.
  logic [TMR_W-1:0] show_ticks, show_nxt;

  always_comb begin
    show_nxt = show_ticks;
    if (state == ST_IDLE) begin
      show_nxt = TMR_W'(MOLE_TICKS);
    end else if (state == ST_SHOW && state_nxt == ST_HIT) begin
      if (32'(show_ticks) >= MIN_MOLE_TICKS + SPEEDUP_STEP) begin
        show_nxt = TMR_W'(32'(show_ticks) - SPEEDUP_STEP);
      end else begin
        show_nxt = TMR_W'(MIN_MOLE_TICKS);
      end
    end
  end

  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      show_ticks <= TMR_W'(MOLE_TICKS);
    end else begin
      show_ticks <= show_nxt;
    end
  end
`else
  logic [TMR_W-1:0] show_ticks;
  assign show_ticks = TMR_W'(MOLE_TICKS);
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    pos_nxt   = mole_position;
    gc_nxt    = guess_correct;
    gw_nxt    = guess_wrong;
    score_nxt = score;
    timer_nxt = timer;
    case (state)
      ST_IDLE: begin
        gc_nxt = 1'b0;
        gw_nxt = 1'b0;
        if (en) begin
          pos_nxt   = fresh_c;
          timer_nxt = TMR_W'(MOLE_TICKS);
          state_nxt = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else if (tog_c != '0) begin
          // A toggle wins over a simultaneous timeout.
          timer_nxt = TMR_W'(FEEDBACK_TICKS);
          if (hit_c) begin
            state_nxt = ST_HIT;
            gc_nxt    = 1'b1;
            score_nxt = (score == SCORE_W'(SCORE_MAX)) ? score : score + SCORE_W'(1);
          end else begin
            state_nxt = ST_MISS;
            gw_nxt    = 1'b1;
          end
        end else if (tick_c) begin
          if (timer == '0) begin
            state_nxt = ST_MISS;
            gw_nxt    = 1'b1;
            timer_nxt = TMR_W'(FEEDBACK_TICKS);
          end else begin
            timer_nxt = timer - TMR_W'(1);
          end
        end
      end
      ST_HIT, ST_MISS: begin
        if (tick_c) begin
          if (timer == '0) begin
            gc_nxt = 1'b0;
            gw_nxt = 1'b0;
            if (en) begin
              pos_nxt   = fresh_c;
              timer_nxt = show_ticks;
              state_nxt = ST_SHOW;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            timer_nxt = timer - TMR_W'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      mole_position <= '0;
      guess_correct <= 1'b0;
      guess_wrong   <= 1'b0;
      score         <= '0;
      timer         <= '0;
    end else begin
      state         <= state_nxt;
      mole_position <= pos_nxt;
      guess_correct <= gc_nxt;
      guess_wrong   <= gw_nxt;
      score         <= score_nxt;
      timer         <= timer_nxt;
    end
  end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Self-checking bench for mole_game_ctrl with a behavioural reference model.
// Honours MOLE_SPEEDUP_EN in the model when the macro is defined.
module tb_mole_game_ctrl;

  localparam int TD   = 4;
  localparam int MT   = 5;
  localparam int FT   = 2;
  localparam int MN   = 2;
  localparam logic [7:0] SEED = 8'hA5;

  localparam int M_IDLE = 0;
  localparam int M_SHOW = 1;
  localparam int M_HIT  = 2;
  localparam int M_MISS = 3;

  logic       master_clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] sw = 8'h00;
  logic [2:0] mole_position;
  logic       guess_correct;
  logic       guess_wrong;
  logic [7:0] score;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_mode, m_pos, m_score, m_tick, m_timer, m_show;
  bit         m_gc, m_gw;
  logic [7:0] m_lfsr;
  logic [7:0] m_sync [3];

  mole_game_ctrl #(
    .TICK_DIV      (TD),
    .MOLE_TICKS    (MT),
    .FEEDBACK_TICKS(FT),
    .MIN_MOLE_TICKS(MN),
    .LFSR_SEED     (SEED)
  ) dut (
    .master_clk   (master_clk),
    .rst          (rst),
    .en           (en),
    .sw           (sw),
    .mole_position(mole_position),
    .guess_correct(guess_correct),
    .guess_wrong  (guess_wrong),
    .score        (score)
  );

  always #5 master_clk = ~master_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] poly_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_pos = 0; m_score = 0; m_tick = 0; m_timer = 0;
    m_show = MT; m_gc = 0; m_gw = 0; m_lfsr = SEED;
    m_sync[0] = 8'h00; m_sync[1] = 8'h00; m_sync[2] = 8'h00;
  endtask

  // One rising edge of the game, from the rules of play.
  task automatic model_clock();
    bit         tick;
    logic [7:0] tog;
    int         cand, fresh;
    if (!rst) begin
      model_reset();
      return;
    end
    tick   = (m_tick == TD - 1);
    m_tick = tick ? 0 : m_tick + 1;
    tog    = m_sync[1] ^ m_sync[2];
    cand   = int'(m_lfsr & 8'h07);
    fresh  = (cand == m_pos) ? (cand + 1) % 8 : cand;
    m_lfsr = poly_step(m_lfsr);
    m_sync[2] = m_sync[1];
    m_sync[1] = m_sync[0];
    m_sync[0] = sw;
    case (m_mode)
      M_IDLE: begin
        m_gc = 0; m_gw = 0; m_show = MT;
        if (en) begin m_pos = fresh; m_timer = MT; m_mode = M_SHOW; end
      end
      M_SHOW: begin
        if (!en) m_mode = M_IDLE;
        else if (tog != 8'h00) begin
          m_timer = FT;
          if ($countones(tog) == 1 && tog[m_pos]) begin
            m_mode = M_HIT; m_gc = 1;
            if (m_score < 255) m_score++;
`ifdef MOLE_SPEEDUP_EN
            m_show = (m_show - 8 < MN) ? MN : m_show - 8;
`endif
          end else begin
            m_mode = M_MISS; m_gw = 1;
          end
        end else if (tick) begin
          if (m_timer == 0) begin m_mode = M_MISS; m_gw = 1; m_timer = FT; end
          else m_timer--;
        end
      end
      default: begin
        if (tick) begin
          if (m_timer == 0) begin
            m_gc = 0; m_gw = 0;
            if (en) begin m_pos = fresh; m_timer = m_show; m_mode = M_SHOW; end
            else m_mode = M_IDLE;
          end else m_timer--;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("pos", 32'(mole_position), 32'(m_pos));
    check("correct", 32'(guess_correct), 32'(m_gc));
    check("wrong", 32'(guess_wrong), 32'(m_gw));
    check("score", 32'(score), 32'(m_score));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge master_clk);
      model_clock();
      #1;
      compare_all();
    end
  endtask

  task automatic wait_show();
    for (int i = 0; i < 60 && m_mode != M_SHOW; i++) step(1);
    check("show_wait", 32'(m_mode), 32'(M_SHOW));
  endtask

  task automatic wait_drop();
    for (int i = 0; i < 40 && (guess_correct === 1'b1 || guess_wrong === 1'b1); i++) step(1);
    check("fb_drop", 32'(guess_correct | guess_wrong), 32'd0);
  endtask

  task automatic async_reset_check(input string tag);
    rst = 1'b0;
    #1;
    model_reset();
    check({tag, "_pos"}, 32'(mole_position), 32'd0);
    check({tag, "_gc"}, 32'(guess_correct), 32'd0);
    check({tag, "_gw"}, 32'(guess_wrong), 32'd0);
    check({tag, "_score"}, 32'(score), 32'd0);
  endtask

  initial begin
    int exp_score, old_pos, n, sc;
    model_reset();
    #2;
    compare_all();
    step(3);

    // Release reset with the game disabled: stays idle
    rst = 1'b1;
    step(6);
    check("idle_pos", 32'(mole_position), 32'd0);
    check("idle_flags", 32'(guess_correct | guess_wrong), 32'd0);

    // Run a little, then assert reset mid-round
    en = 1'b1;
    step(17);
    async_reset_check("rst_mid");
    step(2);
    rst = 1'b1;
    en = 1'b0;
    step(4);
    exp_score = 0;

    // Hit on the mole's hole
    en = 1'b1;
    wait_show();
    old_pos = m_pos;
    sw ^= 8'(1 << m_pos);
    step(2);
    check("hit_early", 32'(guess_correct), 32'd0);
    step(1);
    check("hit_gc", 32'(guess_correct), 32'd1);
    check("hit_gw", 32'(guess_wrong), 32'd0);
    exp_score = 1;
    check("hit_score", 32'(score), 32'(exp_score));
    n = 1;
    while (guess_correct === 1'b1 && n < 30) begin step(1); n++; end
    check("hit_hold", 32'((n - 1 >= 9) && (n - 1 <= 12)), 32'd1);
    check("new_pos_differs", 32'(mole_position != 3'(old_pos)), 32'd1);

    // Wrong switch
    wait_show();
    sw ^= 8'(1 << ((m_pos + 1) % 8));
    step(3);
    check("wrong_gw", 32'(guess_wrong), 32'd1);
    check("wrong_gc", 32'(guess_correct), 32'd0);
    check("wrong_score", 32'(score), 32'(exp_score));
    wait_drop();

    // Timeout, with toggles ignored during the miss feedback
    wait_show();
    n = 0;
    while (guess_wrong !== 1'b1 && n < 40) begin step(1); n++; end
    check("timeout_gw", 32'(guess_wrong), 32'd1);
    check("timeout_delay", 32'((n >= 20) && (n <= 24)), 32'd1);
    sw ^= 8'(1 << m_pos) | 8'h81;
    sc = 0;
    for (int i = 0; i < 40 && guess_wrong === 1'b1; i++) begin
      step(1);
      if (guess_correct === 1'b1) sc++;
    end
    check("miss_ignores_tog", 32'(sc), 32'd0);
    check("miss_score", 32'(score), 32'(exp_score));

    // Two bits on the same edge, one of them the mole's hole
    wait_show();
    sw ^= 8'(1 << m_pos) | 8'(1 << ((m_pos + 3) % 8));
    step(3);
    check("multi_gw", 32'(guess_wrong), 32'd1);
    check("multi_gc", 32'(guess_correct), 32'd0);
    wait_drop();

    // Drive the score to saturation
    for (int h = 0; h < 257; h++) begin
      wait_show();
      sw ^= 8'(1 << m_pos);
      step(3);
      check("sat_hit", 32'(guess_correct), 32'd1);
      exp_score = (exp_score < 255) ? exp_score + 1 : 255;
      wait_drop();
    end
    check("sat_score", 32'(score), 32'd255);

    // Disable during SHOW: back to idle, position held, toggles ignored
    wait_show();
    old_pos = m_pos;
    en = 1'b0;
    step(1);
    sw ^= 8'(1 << old_pos);
    step(6);
    check("dis_gc", 32'(guess_correct), 32'd0);
    check("dis_pos", 32'(mole_position), 32'(old_pos));
    en = 1'b1;
    step(2);

    // Randomised play
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 19) != 0);
      case ($urandom_range(0, 9))
        0: sw ^= 8'(1 << $urandom_range(0, 7));
        1: sw ^= 8'($urandom_range(0, 255));
        2, 3: if (m_mode == M_SHOW) sw ^= 8'(1 << m_pos);
        default: ;
      endcase
      step(1);
    end

    // Reset during hit feedback
    en = 1'b1;
    wait_drop();
    wait_show();
    sw ^= 8'(1 << m_pos);
    step(4);
    check("fb_before_rst", 32'(guess_correct), 32'd1);
    async_reset_check("rst_fb");
    step(2);
    rst = 1'b1;
    step(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
